bundle_sequencer: RTL

- Controller that sequences an element-wise addition datapath to bundle N hypervectors into one.
- Walks the hypervector in chunks of NUM_PARALLEL_KERNELS lanes. For each chunk it fetches vector 0, then adds vectors 1..N-1 into a running accumulator through the external addition kernels.
- Streams each finished chunk out over a ready/valid write port.
- Sits between the hypervector store (read port) and the bundled-vector sink.

---
 rtl/bundle_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/bundle_sequencer.sv
// bundle_sequencer: walks a hypervector in K-lane chunks and sums N stored vectors per chunk.
// The sums go through external add kernels, and each bundled chunk is streamed to a ready/valid sink.
// Optional kernel-wait watchdog: define BUNDLE_SEQ_WATCHDOG_EN.
module bundle_sequencer #(
  parameter int ELEMENT_WIDTH          = 64,
  parameter int HYPERVECTOR_DIMENSIONS = 100,
  parameter int NUM_PARALLEL_KERNELS   = 1,
  parameter int MAX_VECTORS            = 16,
  parameter int TIMEOUT_CYCLES         = 255,
  localparam int EW = ELEMENT_WIDTH,
  localparam int K  = NUM_PARALLEL_KERNELS,
  localparam int D  = HYPERVECTOR_DIMENSIONS,
  localparam int C  = (D + K - 1) / K,
  localparam int NW = $clog2(MAX_VECTORS + 1),
  localparam int CW = (C > 1) ? $clog2(C) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NW-1:0]   num_vectors,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic            ovf_flag,
  output logic            rd_req,
  output logic [NW-1:0]   rd_vec,
  output logic [CW-1:0]   rd_chunk,
  input  logic [K*EW-1:0] rd_data,
  output logic            k_valid,
  output logic            k_bundle_loop,
  output logic [K*EW-1:0] k_elem_A,
  output logic [K*EW-1:0] k_elem_B,
  input  logic [K*EW-1:0] k_elem_out,
  input  logic [K-1:0]    k_overflow,
  input  logic            k_done,
  output logic            wr_valid,
  input  logic            wr_ready,
  output logic [CW-1:0]   wr_chunk,
  output logic [K*EW-1:0] wr_data,
  output logic [K-1:0]    wr_mask
);

  typedef enum logic [3:0] {IDLE, FETCH0, WAIT0, FETCHV, WAITV, ADD, WAITK, WRITE, FIN} state_t;

  state_t          state_q, state_d;
  logic [NW-1:0]   n_q;
  logic [NW-1:0]   v_q;
  logic [CW-1:0]   chunk_q;
  logic [K*EW-1:0] acc_q;
  logic [K*EW-1:0] b_q;
  logic            ovf_q;
  logic            err_q, err_d;
  // Set when the kernel answered in the ADD cycle itself; WAITK then only spends one cycle.
  logic            early_q;
  logic [K-1:0]    lane_mask;
  logic            last_chunk;

`ifdef BUNDLE_SEQ_WATCHDOG_EN
  localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [WDW-1:0] wd_q;
`else
  // The timeout only has meaning when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign last_chunk = (chunk_q == CW'(C - 1));
  assign k_elem_A   = acc_q;
  assign k_elem_B   = b_q;
  assign ovf_flag   = ovf_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; err_d marks a transition into FIN that must report an abort.
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (num_vectors == '0 || num_vectors > NW'(MAX_VECTORS)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end else begin
          state_d = FETCH0;
        end
      end
      FETCH0: state_d = WAIT0;
      WAIT0:  state_d = (n_q == NW'(1)) ? WRITE : FETCHV;
      FETCHV: state_d = WAITV;
      WAITV:  state_d = ADD;
      ADD:    state_d = WAITK;
      WAITK: begin
        if (early_q) begin
          state_d = (v_q == n_q) ? WRITE : FETCHV;
        end else if (k_done) begin
          state_d = (v_q == n_q - NW'(1)) ? WRITE : FETCHV;
        end
`ifdef BUNDLE_SEQ_WATCHDOG_EN
        else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end
`endif
      end
      WRITE:  if (wr_ready) state_d = last_chunk ? FIN : FETCH0;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: N/chunk/vector counters, accumulator, fetched operand and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q     <= '0;
      v_q     <= '0;
      chunk_q <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      early_q <= 1'b0;
`ifdef BUNDLE_SEQ_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      err_q <= err_d;
      case (state_q)
        IDLE: if (start) begin
          ovf_q <= 1'b0;
          if (state_d == FETCH0) begin
            n_q     <= num_vectors;
            chunk_q <= '0;
          end
        end
        WAIT0: begin
          acc_q <= rd_data;
          v_q   <= NW'(1);
        end
        WAITV: b_q <= rd_data;
        ADD: begin
          early_q <= k_done;
`ifdef BUNDLE_SEQ_WATCHDOG_EN
          wd_q    <= '0;
`endif
          if (k_done) begin
            acc_q <= k_elem_out;
            ovf_q <= ovf_q | (|k_overflow);
            v_q   <= v_q + NW'(1);
          end
        end
        WAITK: begin
`ifdef BUNDLE_SEQ_WATCHDOG_EN
          wd_q <= wd_q + WDW'(1);
`endif
          if (!early_q && k_done) begin
            acc_q <= k_elem_out;
            ovf_q <= ovf_q | (|k_overflow);
            v_q   <= v_q + NW'(1);
          end
        end
        WRITE: if (wr_ready && !last_chunk) chunk_q <= chunk_q + CW'(1);
        default: ;
      endcase
    end
  end

  // Lanes past the end of the hypervector are invalid on the last chunk only.
  always_comb begin
    lane_mask = '1;
    if (last_chunk) begin
      for (int i = 0; i < K; i++) begin
        if ((C - 1) * K + i >= D) lane_mask[i] = 1'b0;
      end
    end
  end

  // Output decode; every strobe and index is zero outside the state that owns it.
  always_comb begin
    busy          = (state_q != IDLE) && (state_q != FIN);
    done          = 1'b0;
    error         = 1'b0;
    rd_req        = 1'b0;
    rd_vec        = '0;
    rd_chunk      = '0;
    k_valid       = 1'b0;
    k_bundle_loop = 1'b0;
    wr_valid      = 1'b0;
    wr_chunk      = '0;
    wr_mask       = '0;
    wr_data       = '0;
    case (state_q)
      FETCH0: begin
        rd_req   = 1'b1;
        rd_chunk = chunk_q;
      end
      FETCHV: begin
        rd_req   = 1'b1;
        rd_vec   = v_q;
        rd_chunk = chunk_q;
      end
      ADD: begin
        k_valid       = 1'b1;
        k_bundle_loop = (v_q >= NW'(2));
      end
      WRITE: begin
        wr_valid = 1'b1;
        wr_chunk = chunk_q;
        wr_mask  = lane_mask;
        for (int i = 0; i < K; i++) begin
          wr_data[i*EW +: EW] = lane_mask[i] ? acc_q[i*EW +: EW] : '0;
        end
      end
      FIN: begin
        done  = 1'b1;
        error = err_q;
      end
      default: ;
    endcase
  end

endmodule
